// File: rtl/opb_register_simulink2ppc_pkg.sv
// opb_register_simulink2ppc_pkg: shared FSM encodings, register word offsets and STAT packing
package opb_register_simulink2ppc_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [29:0] W_DATA = 30'd0;
  localparam logic [29:0] W_STAT = 30'd1;
  localparam logic [29:0] W_CTRL = 30'd2;
  function automatic logic [31:0] stat_word(input logic [15:0] cnt, input logic ovr, input logic nw);
    return {cnt, 14'd0, ovr, nw};
  endfunction
endpackage

// File: rtl/opb_slave_if.sv
// opb_slave_if: OPB slave window decode, IDLE/ACK/WAIT handshake and wired-OR read-data gating
// ports: clk/rst, OPB abus/wdata/be/rnw/select in; rd_word from owner's read mux (indexed by word_idx);
//        ack plus the transfer captured at select time (ack_rnw/ack_idx/ack_wdata/ack_be); dbus read data
module opb_slave_if
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'h01001000,
  parameter logic [31:0] HIGHADDR = 32'h010010FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:31] abus,
  input  logic [0:31] wdata,
  input  logic [0:3]  be,
  input  logic        rnw,
  input  logic        select,
  input  logic [31:0] rd_word,
  output logic [29:0] word_idx,
  output logic        ack,
  output logic        ack_rnw,
  output logic [29:0] ack_idx,
  output logic [0:31] ack_wdata,
  output logic [0:3]  ack_be,
  output logic [0:31] dbus
);
  logic [1:0] st;
  logic [31:0] off;
  logic [31:0] rd_q;
  logic hit;
  logic unused_ok;
  assign off = abus - BASEADDR;
  assign word_idx = off[31:2];
  assign unused_ok = ^off[1:0];
  assign hit = select && abus >= BASEADDR && abus <= HIGHADDR;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE;
      rd_q <= '0;
      ack_rnw <= 1'b0;
      ack_idx <= '0;
      ack_wdata <= '0;
      ack_be <= '0;
    end else begin
      st <= st == ST_IDLE ? (hit ? ST_ACK : ST_IDLE) : st == ST_ACK ? ST_WAIT : (select ? ST_WAIT : ST_IDLE);
      if (st == ST_IDLE && hit) begin
        rd_q <= rnw ? rd_word : '0;
        ack_rnw <= rnw;
        ack_idx <= word_idx;
        ack_wdata <= wdata;
        ack_be <= be;
      end
    end
  assign ack = st == ST_ACK;
  assign dbus = ack ? rd_q : '0;
endmodule

// File: rtl/opb_register_simulink2ppc.sv
// opb_register_simulink2ppc: fabric-to-PPC register with NEW/OVERRUN flags and update count, read over OPB
// ports: OPB_Clk/OPB_Rst; OPB_ABus/BE/DBus/RNW/select/seqAddr slave inputs; Sl_DBus/xferAck (errAck/retry/toutSup
//        tied 0); user_data_in + user_data_valid capture a word each valid cycle; user_new_pending mirrors NEW
module opb_register_simulink2ppc
  import opb_register_simulink2ppc_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01001000,
  parameter logic [31:0] C_HIGHADDR = 32'h010010FF,
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter C_FAMILY = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid,
  output logic                    user_new_pending
);
  localparam bit unused_family = C_FAMILY == "";
  logic [31:0] data;
  logic nw;
  logic ovr;
  logic [15:0] cnt;
  logic [29:0] word_idx;
  logic [29:0] ack_idx;
  logic ack;
  logic ack_rnw;
  logic [0:31] ack_wdata;
  logic [0:3] ack_be;
  logic [31:0] rd_word;
  logic rd_clr;
  logic ctrl_clr;
  logic unused_ok;
  opb_slave_if #(.BASEADDR(C_BASEADDR), .HIGHADDR(C_HIGHADDR)) u_if (
    .clk(OPB_Clk), .rst(OPB_Rst), .abus(OPB_ABus), .wdata(OPB_DBus), .be(OPB_BE), .rnw(OPB_RNW),
    .select(OPB_select), .rd_word(rd_word), .word_idx(word_idx), .ack(ack), .ack_rnw(ack_rnw),
    .ack_idx(ack_idx), .ack_wdata(ack_wdata), .ack_be(ack_be), .dbus(Sl_DBus)
  );
  assign rd_word = word_idx == W_DATA ? data : word_idx == W_STAT ? stat_word(cnt, ovr, nw) : '0;
  assign rd_clr = ack && ack_rnw && ack_idx == W_DATA;
  // OPB bit 31 is the LSB, so the CTRL clear bit lives in the BE[3] byte lane
  assign ctrl_clr = ack && !ack_rnw && ack_idx == W_CTRL && ack_be[3] && ack_wdata[31];
  // a valid arriving with the clearing read keeps NEW set and is not an overrun
  always_ff @(posedge OPB_Clk or posedge OPB_Rst)
    if (OPB_Rst) begin
      data <= '0;
      nw <= 1'b0;
      ovr <= 1'b0;
      cnt <= '0;
    end else begin
      if (user_data_valid) data <= user_data_in;
      nw <= user_data_valid | (nw & ~rd_clr);
      ovr <= ~ctrl_clr & (ovr | (user_data_valid & nw & ~rd_clr));
      cnt <= ctrl_clr ? {15'd0, user_data_valid} : cnt + {15'd0, user_data_valid};
    end
  assign Sl_xferAck = ack;
  assign Sl_errAck = 1'b0;
  assign Sl_retry = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_new_pending = nw;
  assign unused_ok = ^{ack_wdata[0:30], ack_be[0:2], OPB_seqAddr, unused_family};
endmodule
